// File: rtl/mwc_pkg.sv
// Shared types for the memory write checker.
// State and failure-cause encodings.
package mwc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_BAD_ADR  = 2'd1,
    FC_BAD_DATA = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fail_code_t;

endpackage

// File: rtl/mem_write_checker_cycle_timer.sv
// Saturating RUN-cycle counter; expired while count == TIMEOUT.
// Ports: clk, reset (sync, active-low), clear, en, expired.
module cycle_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_write_checker.sv
// Compares bus stores in order against a loadable expected table.
// Ports: table load, start, bus monitor inputs; done/pass/fail/cause/captures.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 4096,
  parameter int IGNORE_EN  = 1,
  parameter int IGNORE_ADR = 80,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [IW-1:0]    load_idx,
  input  logic [WIDTH-1:0] load_adr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [IW:0]      match_count,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data
);

  localparam logic [WIDTH-1:0] IGN = WIDTH'(IGNORE_ADR);
  localparam logic [IW:0] LAST = (IW+1)'(DEPTH);

  state_t state, state_n;
  fail_code_t code_n;
  logic [IW:0] mc_n;
  logic [WIDTH-1:0] fa_n, fd_n;
  logic [WIDTH-1:0] exp_adr [DEPTH];
  logic [WIDTH-1:0] exp_data [DEPTH];
  logic [WIDTH-1:0] cur_adr, cur_data;
  logic adr_hit, data_hit, ign_hit;
  logic tmr_clear, expired;

  cycle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .en      (state == RUN),
    .expired (expired)
  );

  // Table writes only in IDLE; out-of-range indices match no entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset) begin
        exp_adr[i]  <= '0;
        exp_data[i] <= '0;
      end else if (load_en && state == IDLE &&
                   load_idx == IW'(i)) begin
        exp_adr[i]  <= load_adr;
        exp_data[i] <= load_data;
      end
    end
  end

  always_comb begin
    cur_adr  = '0;
    cur_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_count == (IW+1)'(i)) begin
        cur_adr  = exp_adr[i];
        cur_data = exp_data[i];
      end
    end
  end

  assign adr_hit  = (dataadr == cur_adr);
  assign data_hit = (writedata == cur_data);
  assign ign_hit  = (IGNORE_EN != 0) && (dataadr == IGN);

  always_comb begin
    state_n   = state;
    code_n    = fail_code_t'(fail_code);
    mc_n      = match_count;
    fa_n      = fail_adr;
    fd_n      = fail_data;
    tmr_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = RUN;
          mc_n      = '0;
          tmr_clear = 1'b1;
        end
      end
      RUN: begin
        // Expected-store match precedes the scratch-address skip.
        if (memwrite) begin
          if (adr_hit && data_hit) begin
            mc_n = match_count + 1'b1;
            if (mc_n == LAST) state_n = PASS;
          end else if (!ign_hit) begin
            state_n = FAIL;
            code_n  = adr_hit ? FC_BAD_DATA : FC_BAD_ADR;
            fa_n    = dataadr;
            fd_n    = writedata;
          end
        end
        // A store that resolves the run beats the timeout.
        if (state_n == RUN && expired) begin
          state_n = FAIL;
          code_n  = FC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= 2'd0;
      match_count <= '0;
      fail_adr    <= '0;
      fail_data   <= '0;
    end else begin
      state       <= state_n;
      done        <= (state_n == PASS) || (state_n == FAIL);
      pass        <= (state_n == PASS);
      fail        <= (state_n == FAIL);
      fail_code   <= code_n;
      match_count <= mc_n;
      fail_adr    <= fa_n;
      fail_data   <= fd_n;
    end
  end

endmodule
